// File: rtl/rvv_cmd_scheduler.sv
// In-order command queue between the RVV front end and the vector backend.
// It accepts up to N aligned commands per cycle and issues one per cycle over valid/ready.
module rvv_cmd_scheduler #(
    parameter int N            = 4,
    parameter int DEPTH        = 8,
    parameter int DATA_W       = 32,
    parameter int CAPACITYBITS = $clog2(DEPTH + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N-1:0]                 cmd_valid_i,
    input  logic [N-1:0][DATA_W-1:0]     cmd_data_i,
    output logic [CAPACITYBITS-1:0]      queue_capacity_o,
    output logic                         issue_valid_o,
    output logic [DATA_W-1:0]            issue_data_o,
    input  logic                         issue_ready_i,
    input  logic                         flush_i,
    output logic [CAPACITYBITS-1:0]      occupancy_o,
    output logic                         overflow_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0]       mem [DEPTH];
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic [CAPACITYBITS-1:0] count_q;
    logic [CAPACITYBITS-1:0] free;
    logic [CAPACITYBITS-1:0] k;
    logic [CAPACITYBITS-1:0] accept;
    logic                    deq;

    always_comb begin
        k = '0;
        for (int j = 0; j < N; j++) begin
            k = k + CAPACITYBITS'(cmd_valid_i[j]);
        end
    end

    // Free space comes from registered state only, so a same-cycle dequeue never makes room.
    assign free   = CAPACITYBITS'(DEPTH) - count_q;
    assign accept = (k > free) ? free : k;
    assign deq    = issue_valid_o && issue_ready_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            wr_ptr  <= wr_ptr + PTR_W'(accept);
            rd_ptr  <= rd_ptr + PTR_W'(deq);
            count_q <= count_q + accept - CAPACITYBITS'(deq);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_o <= 1'b0;
        end else if (!flush_i && (k > free)) begin
            overflow_o <= 1'b1;
        end
    end

    // Pointer arithmetic wraps naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!flush_i) begin
            for (int j = 0; j < N; j++) begin
                if (CAPACITYBITS'(j) < accept) begin
                    mem[wr_ptr + PTR_W'(j)] <= cmd_data_i[j];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert ((cmd_valid_i & (cmd_valid_i + N'(1))) == '0)
            else $error("rvv_cmd_scheduler: non-contiguous cmd_valid_i %b", cmd_valid_i);
        end
    end

    assign issue_valid_o    = (count_q != '0);
    assign issue_data_o     = mem[rd_ptr];
    assign occupancy_o      = count_q;
    assign queue_capacity_o = free;

endmodule

// File: tb/tb_rvv_cmd_scheduler.sv
// Directed bench for rvv_cmd_scheduler: reset, fill/drain, wrap, overlap, overflow, flush.
module tb_rvv_cmd_scheduler;

    logic              clk = 1'b0;
    logic              rst;
    logic [3:0]        cmd_valid;
    logic [3:0][31:0]  cmd_data;
    logic [3:0]        queue_capacity;
    logic              issue_valid;
    logic [31:0]       issue_data;
    logic              issue_ready;
    logic              flush;
    logic [3:0]        occupancy;
    logic              overflow;

    int n_checks = 0;
    int n_fail   = 0;

    rvv_cmd_scheduler #(.N(4), .DEPTH(8), .DATA_W(32)) dut (
        .clk              (clk),
        .rst              (rst),
        .cmd_valid_i      (cmd_valid),
        .cmd_data_i       (cmd_data),
        .queue_capacity_o (queue_capacity),
        .issue_valid_o    (issue_valid),
        .issue_data_o     (issue_data),
        .issue_ready_i    (issue_ready),
        .flush_i          (flush),
        .occupancy_o      (occupancy),
        .overflow_o       (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic enq(input logic [3:0] v, input logic [31:0] base);
        cmd_valid = v;
        for (int j = 0; j < 4; j++) cmd_data[j] = base + 32'(j);
    endtask

    task automatic status(input string tag, input logic vld, input logic [3:0] occ, input logic ovf);
        chk({tag, "_valid"}, 32'(issue_valid), 32'(vld));
        chk({tag, "_occ"}, 32'(occupancy), 32'(occ));
        chk({tag, "_cap"}, 32'(queue_capacity), 32'(4'd8 - occ));
        chk({tag, "_ovf"}, 32'(overflow), 32'(ovf));
    endtask

    // Dequeue n entries with ready held high, checking head order and the falling occupancy.
    task automatic drain(input string tag, input int n, input logic [31:0] first, input logic ovf);
        issue_ready = 1'b1;
        cmd_valid   = '0;
        for (int i = 0; i < n; i++) begin
            chk({tag, "_head"}, issue_data, first + 32'(i));
            tick();
            chk({tag, "_occ"}, 32'(occupancy), 32'(n - 1 - i));
            chk({tag, "_cap"}, 32'(queue_capacity), 32'(8 - (n - 1 - i)));
        end
        issue_ready = 1'b0;
        status({tag, "_end"}, 1'b0, 4'd0, ovf);
    endtask

    initial begin
        rst = 1'b1;
        cmd_valid = '0;
        cmd_data = '0;
        issue_ready = 1'b0;
        flush = 1'b0;
        tick();
        tick();
        status("reset", 1'b0, 4'd0, 1'b0);
        rst = 1'b0;
        tick();

        // Fill to full with ready low, then drain in order.
        enq(4'b1111, 32'h10);
        tick();
        status("fill1", 1'b1, 4'd4, 1'b0);
        chk("fill1_head", issue_data, 32'h10);
        enq(4'b1111, 32'h14);
        tick();
        status("fill2", 1'b1, 4'd8, 1'b0);
        cmd_valid = '0;
        tick();
        chk("stall_head", issue_data, 32'h10);
        chk("stall_occ", 32'(occupancy), 32'd8);
        drain("drain", 8, 32'h10, 1'b0);

        // Move both pointers to 6, then enqueue four across the wrap point.
        enq(4'b1111, 32'h20);
        tick();
        enq(4'b0011, 32'h24);
        tick();
        chk("pre_wrap_occ", 32'(occupancy), 32'd6);
        drain("predrain", 6, 32'h20, 1'b0);
        enq(4'b1111, 32'hA0);
        tick();
        status("wrap", 1'b1, 4'd4, 1'b0);
        drain("wrapdrain", 4, 32'hA0, 1'b0);

        // Enqueue and dequeue in the same cycle.
        enq(4'b0111, 32'h30);
        tick();
        chk("sim_pre_occ", 32'(occupancy), 32'd3);
        issue_ready = 1'b1;
        enq(4'b0011, 32'h33);
        tick();
        chk("sim_occ", 32'(occupancy), 32'd4);
        chk("sim_head", issue_data, 32'h31);
        drain("simdrain", 4, 32'h31, 1'b0);

        // Overflow: six held, four offered; only two fit.
        enq(4'b1111, 32'h40);
        tick();
        enq(4'b0011, 32'h44);
        tick();
        status("ovf_pre", 1'b1, 4'd6, 1'b0);
        enq(4'b1111, 32'h46);
        tick();
        status("ovf", 1'b1, 4'd8, 1'b1);
        cmd_valid = '0;
        tick();
        chk("ovf_sticky", 32'(overflow), 32'd1);
        drain("ovfdrain", 8, 32'h40, 1'b1);

        // Flush with a concurrent enqueue and dequeue handshake.
        enq(4'b1111, 32'h50);
        tick();
        enq(4'b0001, 32'h54);
        tick();
        chk("flush_pre_occ", 32'(occupancy), 32'd5);
        flush = 1'b1;
        issue_ready = 1'b1;
        enq(4'b0111, 32'h58);
        tick();
        flush = 1'b0;
        issue_ready = 1'b0;
        status("flush", 1'b0, 4'd0, 1'b1);
        enq(4'b0001, 32'h60);
        tick();
        status("post_flush", 1'b1, 4'd1, 1'b1);
        chk("post_flush_head", issue_data, 32'h60);
        drain("pfdrain", 1, 32'h60, 1'b1);

        // Asynchronous reset mid-stream with five entries held.
        enq(4'b1111, 32'h70);
        tick();
        enq(4'b0001, 32'h74);
        tick();
        cmd_valid = '0;
        chk("rst_pre_occ", 32'(occupancy), 32'd5);
        #2;
        rst = 1'b1;
        #1;
        status("async_rst", 1'b0, 4'd0, 1'b0);
        #1;
        rst = 1'b0;
        enq(4'b0001, 32'h80);
        tick();
        status("post_rst", 1'b1, 4'd1, 1'b0);
        chk("post_rst_head", issue_data, 32'h80);
        cmd_valid = '0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/rvv_cmd_scheduler.md
# rvv_cmd_scheduler

Command queue and issue scheduler between the RVV front end and the vector backend. Each cycle it takes up to N aligned `RVVCmd`s from the front end and issues them one at a time, in program order, over a valid/ready handshake. It reports free capacity so the front end can back-pressure instruction acceptance. It also supports a flush on trap.

## Interface
Parameters:
- `N`, 4: front-end command width (enqueue lanes per cycle).
- `DEPTH`, 8: queue entries; must be a power of two and ≥ N.
- `CAPACITYBITS`, `$clog2(DEPTH+1)`: width of capacity and occupancy counts.

Ports:
- `clk`  in  1  clock; single clock domain.
- `rst`  in  1  asynchronous, active-high reset.
- `cmd_valid_i`  in  N  aligned enqueue valids (contiguous from lane 0).
- `cmd_data_i`  in  N×`RVVCmd`  commands; lane 0 is oldest.
- `queue_capacity_o`  out  CAPACITYBITS  free entries (DEPTH − occupancy); drives the front end's `queue_capacity_i`.
- `issue_valid_o`  out  1  head command is valid.
- `issue_data_o`  out  `RVVCmd`  head command.
- `issue_ready_i`  in  1  backend accepts the head this cycle.
- `flush_i`  in  1  discard all queued and same-cycle commands (trap).
- `occupancy_o`  out  CAPACITYBITS  entries currently held.
- `overflow_o`  out  1  sticky error: an enqueue exceeded free capacity.

## Operation
- **Storage:** DEPTH-entry circular buffer with `wr_ptr` and `rd_ptr` (log2(DEPTH) bits, wrap modulo DEPTH) and `count_q` (CAPACITYBITS bits).
- **Enqueue count:** k = popcount(`cmd_valid_i`). Lane j is written to `mem[(wr_ptr + j) mod DEPTH]` for j < k. `wr_ptr` advances by k.
- **Non-contiguous valids** (e.g. 4'b0101) are illegal. They are a simulation assertion failure; RTL behaviour is undefined.
- **Dequeue:** d = `issue_valid_o && issue_ready_i`. `rd_ptr` advances by d.
- **Count update:** `count_q` ← `count_q` + k − d.
- **Outputs:** `issue_valid_o` = (`count_q` ≠ 0). `issue_data_o` = `mem[rd_ptr]`, and is don't-care when not valid. `occupancy_o` = `count_q`. `queue_capacity_o` = DEPTH − `count_q`.
- **Capacity is computed from registered state only.** A dequeue in the current cycle does not raise capacity until the next cycle; this is deliberately conservative.
- **Overflow:** if k > DEPTH − `count_q`:
  - only the first DEPTH − `count_q` lanes are written;
  - the excess lanes are dropped;
  - `overflow_o` is set and stays set until `rst`.
- **Simultaneous enqueue and dequeue at full:** there is no freed-slot reuse in the same cycle. The k ≤ capacity check uses `count_q`, not `count_q` − d.
- **Flush:** `flush_i` has priority over enqueue and dequeue. On the next edge `count_q`, `wr_ptr` and `rd_ptr` are set to 0, and same-cycle enqueues are dropped. A dequeue handshake in the flush cycle still counts as accepted by the backend; the entry is simply not re-issued. `overflow_o` is not cleared by flush.
- **Ordering:** strict FIFO. Lane order within a cycle is preserved, and all lanes of cycle t are issued before those of cycle t+1.
- **Entry storage** needs no reset; only pointers, count and `overflow_o` are reset.

## Timing
- **Reset values:** `issue_valid_o`=0, `occupancy_o`=0, `queue_capacity_o`=DEPTH, `overflow_o`=0, `issue_data_o`=don't-care.
- **Enqueue-to-issue latency:** a command enqueued at edge t appears on `issue_*` from t+1 when the queue was empty. There is no combinational bypass from `cmd_*` to `issue_*`.
- **Throughput:** one issue per cycle sustained. Enqueue bandwidth is up to N per cycle.
- **Handshake:** `issue_valid_o` does not depend on `issue_ready_i`. The head stays stable while valid and not ready, unless flushed.
- **No combinational paths** from any input to `queue_capacity_o`, `occupancy_o` or `issue_valid_o`.
- **Wrap-around:** pointer increments cross DEPTH−1 → 0 within a multi-lane enqueue. For example, `wr_ptr`=6 with k=4 writes entries 6, 7, 0, 1.
- **Reset mid-operation:** `rst` asserted asynchronously clears state immediately, and outputs take their reset values within the same cycle. Commands are lost.

## Test plan
- **Reset:** assert `rst` mid-stream with 5 entries held → `issue_valid_o`=0, `occupancy_o`=0 and `queue_capacity_o`=8 immediately; first post-reset enqueue issues normally.
- **Fill and drain:** with `issue_ready_i`=0, enqueue 4'b1111 twice → `occupancy_o`=8 and `queue_capacity_o`=0. Then `issue_ready_i`=1 → 8 commands issued in lane/cycle order over 8 cycles; `queue_capacity_o` rises 1 per cycle, lagging one cycle.
- **Wrap-around:** advance pointers to 6, enqueue 4 commands A–D → issue order A, B, C, D; `mem` slots 6, 7, 0, 1 used; `occupancy_o`=4.
- **Simultaneous enqueue/dequeue:** `count_q`=3 with ready=1, enqueue 2 → `occupancy_o`=4 next cycle; head order preserved.
- **Overflow:** `count_q`=6, enqueue 4'b1111 → lanes 0–1 stored, lanes 2–3 dropped, `overflow_o`=1 and held; a later flush leaves it at 1.
- **Flush:** 5 entries held, then assert `flush_i` together with an enqueue of 3 and a dequeue handshake → next cycle `issue_valid_o`=0, `occupancy_o`=0, `queue_capacity_o`=8; the subsequent enqueue issues at t+1.
